// File: rtl/frame_scan_reader_pkg.sv
// cam_pkg: shared definitions for the camera frame buffer read side.
//   IMAGE_WIDTH / IMAGE_HEIGHT : default frame geometry (row-major BRAM layout)
//   COL_BITS / ROW_BITS        : widths of the col/row coordinate outputs
//   pixel_t                    : 12-bit RGB444 pixel as stored in the frame BRAM
//   scan_state_t               : states of the read sequencer
package cam_pkg;

  localparam int IMAGE_WIDTH  = 320;
  localparam int IMAGE_HEIGHT = 240;
  localparam int COL_BITS     = 9;
  localparam int ROW_BITS     = 8;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } pixel_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    DRAIN,
    DONE
  } scan_state_t;

endpackage

// File: rtl/frame_scan_reader_if.sv
// frame_scan_reader_if: bundles the frame trigger, the BRAM read port and the
// aligned pixel stream of frame_scan_reader.
//   master : the reader (takes frame_ready/bram_q, drives address and pixel stream)
//   slave  : the environment (camera write side, BRAM, pixel consumers)
interface frame_scan_reader_if #(
  parameter int ADDR_BITS = 17
);
  import cam_pkg::*;

  logic                 frame_ready;
  logic [ADDR_BITS-1:0] bram_rdaddress;
  pixel_t               bram_q;
  logic [ADDR_BITS-1:0] rdaddress;
  pixel_t               rddata;
  logic [COL_BITS-1:0]  col;
  logic [ROW_BITS-1:0]  row;
  logic                 pixel_valid;
  logic                 busy;
  logic                 frame_done;

  modport master (
    input  frame_ready, bram_q,
    output bram_rdaddress, rdaddress, rddata, col, row, pixel_valid, busy, frame_done
  );

  modport slave (
    output frame_ready, bram_q,
    input  bram_rdaddress, rdaddress, rddata, col, row, pixel_valid, busy, frame_done
  );

endinterface

// File: rtl/frame_scan_reader_align_pipe.sv
// scan_align_pipe: DEPTH-stage shift register that delays the scan tag
// {valid, addr, col, row} so it lines up with BRAM read data.
//   clk, reset            : clock, synchronous active-high reset (clears all stages)
//   in_valid/addr/col/row : tag for the address issued this cycle
//   out_valid/addr/col/row: tag issued DEPTH cycles ago
module scan_align_pipe
  import cam_pkg::*;
#(
  parameter int DEPTH     = 2,
  parameter int ADDR_BITS = 17
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [ADDR_BITS-1:0] in_addr,
  input  logic [COL_BITS-1:0]  in_col,
  input  logic [ROW_BITS-1:0]  in_row,
  output logic                 out_valid,
  output logic [ADDR_BITS-1:0] out_addr,
  output logic [COL_BITS-1:0]  out_col,
  output logic [ROW_BITS-1:0]  out_row
);

  typedef struct packed {
    logic                 valid;
    logic [ADDR_BITS-1:0] addr;
    logic [COL_BITS-1:0]  col;
    logic [ROW_BITS-1:0]  row;
  } tag_t;

  tag_t stage_q [DEPTH];
  tag_t stage_d [DEPTH];

  always_comb begin
    stage_d[0] = '{valid: in_valid, addr: in_addr, col: in_col, row: in_row};
    for (int i = 1; i < DEPTH; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= stage_d[i];
      end
    end
  end

  assign out_valid = stage_q[DEPTH-1].valid;
  assign out_addr  = stage_q[DEPTH-1].addr;
  assign out_col   = stage_q[DEPTH-1].col;
  assign out_row   = stage_q[DEPTH-1].row;

endmodule

// File: rtl/frame_scan_reader.sv
// frame_scan_reader: read-side sequencer for the camera frame BRAM.
// Each accepted frame_ready sweeps BRAM addresses 0..N-1 once and presents
// every returned pixel with its address, column and row.
//   clk, reset          : clock, synchronous active-high reset
//   bus.frame_ready     : 1-cycle pulse, a complete frame is in BRAM
//   bus.bram_rdaddress  : BRAM read address (parked at 0 between scans)
//   bus.bram_q          : BRAM data, READ_LATENCY cycles after its address
//   bus.rdaddress/rddata/col/row/pixel_valid : aligned pixel stream
//   bus.busy            : scan in progress
//   bus.frame_done      : 1-cycle pulse after the last pixel of a scan
module frame_scan_reader #(
  parameter int IMAGE_WIDTH  = cam_pkg::IMAGE_WIDTH,
  parameter int IMAGE_HEIGHT = cam_pkg::IMAGE_HEIGHT,
  parameter int ADDR_BITS    = $clog2(IMAGE_WIDTH * IMAGE_HEIGHT),
  parameter int READ_LATENCY = 2
) (
  input  logic                clk,
  input  logic                reset,
  frame_scan_reader_if.master bus
);
  import cam_pkg::*;

  localparam int                   NUM_PIXELS = IMAGE_WIDTH * IMAGE_HEIGHT;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR  = ADDR_BITS'(NUM_PIXELS - 1);
  localparam logic [COL_BITS-1:0]  LAST_COL   = COL_BITS'(IMAGE_WIDTH - 1);
  // DRAIN lasts READ_LATENCY+1 cycles: the pipe empties and the last pixel
  // also leaves the output register, so DONE falls on the cycle after it.
  localparam logic [2:0]           DRAIN_LAST = 3'(READ_LATENCY);

  scan_state_t          state_q, state_d;
  logic                 pending_q, pending_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [COL_BITS-1:0]  col_cnt_q, col_cnt_d;
  logic [ROW_BITS-1:0]  row_cnt_q, row_cnt_d;
  logic [2:0]           drain_cnt_q, drain_cnt_d;

  logic                 tail_valid;
  logic [ADDR_BITS-1:0] tail_addr;
  logic [COL_BITS-1:0]  tail_col;
  logic [ROW_BITS-1:0]  tail_row;

  logic                 pixel_valid_q, pixel_valid_d;
  logic [ADDR_BITS-1:0] rdaddress_q, rdaddress_d;
  logic [COL_BITS-1:0]  out_col_q, out_col_d;
  logic [ROW_BITS-1:0]  out_row_q, out_row_d;
  pixel_t               rddata_q, rddata_d;

  // Sequencer: next state, address/col/row counters, pending request
  always_comb begin
    state_d     = state_q;
    pending_d   = pending_q;
    addr_d      = addr_q;
    col_cnt_d   = col_cnt_q;
    row_cnt_d   = row_cnt_q;
    drain_cnt_d = drain_cnt_q;
    case (state_q)
      IDLE: begin
        addr_d    = '0;
        col_cnt_d = '0;
        row_cnt_d = '0;
        if (bus.frame_ready || pending_q) begin
          state_d   = ISSUE;
          pending_d = 1'b0;
        end
      end
      ISSUE: begin
        if (bus.frame_ready) pending_d = 1'b1;
        if (addr_q == LAST_ADDR) begin
          // counters return to 0 so the read port parks at the latch address
          state_d     = DRAIN;
          addr_d      = '0;
          col_cnt_d   = '0;
          row_cnt_d   = '0;
          drain_cnt_d = '0;
        end else begin
          addr_d = addr_q + 1'b1;
          if (col_cnt_q == LAST_COL) begin
            col_cnt_d = '0;
            row_cnt_d = row_cnt_q + 1'b1;
          end else begin
            col_cnt_d = col_cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (bus.frame_ready) pending_d = 1'b1;
        if (drain_cnt_q == DRAIN_LAST) begin
          state_d = DONE;
        end else begin
          drain_cnt_d = drain_cnt_q + 1'b1;
        end
      end
      DONE: begin
        // a request collected during the scan (or arriving now) starts the
        // next sweep immediately, without passing through IDLE
        if (bus.frame_ready || pending_q) begin
          state_d   = ISSUE;
          pending_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  scan_align_pipe #(
    .DEPTH     (READ_LATENCY),
    .ADDR_BITS (ADDR_BITS)
  ) u_align (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (state_q == ISSUE),
    .in_addr   (addr_q),
    .in_col    (col_cnt_q),
    .in_row    (row_cnt_q),
    .out_valid (tail_valid),
    .out_addr  (tail_addr),
    .out_col   (tail_col),
    .out_row   (tail_row)
  );

  // Output stage: coordinates forced to 0 outside an active scan
  always_comb begin
    pixel_valid_d = tail_valid;
    rdaddress_d   = tail_valid ? tail_addr : '0;
    out_col_d     = tail_valid ? tail_col  : '0;
    out_row_d     = tail_valid ? tail_row  : '0;
    rddata_d      = bus.bram_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      pending_q     <= 1'b0;
      addr_q        <= '0;
      col_cnt_q     <= '0;
      row_cnt_q     <= '0;
      drain_cnt_q   <= '0;
      pixel_valid_q <= 1'b0;
      rdaddress_q   <= '0;
      out_col_q     <= '0;
      out_row_q     <= '0;
      rddata_q      <= '0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      addr_q        <= addr_d;
      col_cnt_q     <= col_cnt_d;
      row_cnt_q     <= row_cnt_d;
      drain_cnt_q   <= drain_cnt_d;
      pixel_valid_q <= pixel_valid_d;
      rdaddress_q   <= rdaddress_d;
      out_col_q     <= out_col_d;
      out_row_q     <= out_row_d;
      rddata_q      <= rddata_d;
    end
  end

  assign bus.bram_rdaddress = addr_q;
  assign bus.rdaddress      = rdaddress_q;
  assign bus.rddata         = rddata_q;
  assign bus.col            = out_col_q;
  assign bus.row            = out_row_q;
  assign bus.pixel_valid    = pixel_valid_q;
  assign bus.busy           = (state_q != IDLE);
  assign bus.frame_done     = (state_q == DONE);

endmodule

// File: tb/tb_frame_scan_reader.sv
// Bench for frame_scan_reader: three instances (READ_LATENCY 1, 2, 4) on a
// 20x12 frame share one stimulus stream; each has its own BRAM model
// (data = address) and a scan-index reference model checked every cycle.
module tb_frame_scan_reader;
  import cam_pkg::*;

  localparam int W  = 20;
  localparam int H  = 12;
  localparam int N  = W * H;
  localparam int AB = $clog2(N);

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic reset = 1'b1;
  logic frame_ready = 1'b0;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  bit lat_req = 1'b0;
  int t0 = -100;

  task automatic check(string name, int lat, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      if (errors <= 40)
        $display("FAIL %s (READ_LATENCY=%0d) cycle %0d: got %0d expected %0d",
                 name, lat, cyc, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 3; gi++) begin : g_lat
    localparam int RL = (gi == 0) ? 1 : ((gi == 1) ? 2 : 4);

    frame_scan_reader_if #(.ADDR_BITS(AB)) bus ();
    assign bus.frame_ready = frame_ready;

    frame_scan_reader #(
      .IMAGE_WIDTH  (W),
      .IMAGE_HEIGHT (H),
      .ADDR_BITS    (AB),
      .READ_LATENCY (RL)
    ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
    );

    // BRAM model: returns the address itself, RL cycles later
    logic [11:0] q_pipe [RL];
    always @(posedge clk) begin
      q_pipe[0] <= 12'(bus.bram_rdaddress);
      for (int i = 1; i < RL; i++) q_pipe[i] <= q_pipe[i-1];
    end
    assign bus.bram_q = pixel_t'(q_pipe[RL-1]);

    // Reference model: a scan is a run of cycles indexed k = 0..N+RL+1.
    // Addresses go out for k < N, pixel k-RL-1 is shown, k = N+RL+1 is done.
    bit m_active = 1'b0;
    bit m_pend   = 1'b0;
    bit m_armed  = 1'b0;
    int m_k      = 0;
    int valid_cnt = 0;
    int lat_for   = -1;

    initial begin : model
      forever begin
        @(posedge clk);
        if (reset) begin
          m_active  = 1'b0;
          m_pend    = 1'b0;
          m_k       = 0;
          m_armed   = 1'b1;
          valid_cnt = 0;
        end else if (!m_active) begin
          if (frame_ready) begin
            m_active = 1'b1;
            m_k      = 0;
          end
        end else if (m_k == N + RL + 1) begin
          if (m_pend || frame_ready) begin
            m_k    = 0;
            m_pend = 1'b0;
          end else begin
            m_active = 1'b0;
          end
        end else begin
          m_k = m_k + 1;
          if (frame_ready) m_pend = 1'b1;
        end
      end
    end

    initial begin : compare
      bit ev;
      int ea;
      forever begin
        @(negedge clk);
        if (m_armed) begin
          ev = m_active && (m_k >= RL + 1) && (m_k <= N + RL);
          ea = ev ? (m_k - RL - 1) : 0;
          check("pixel_valid", RL, int'(bus.pixel_valid), int'(ev));
          check("busy", RL, int'(bus.busy), int'(m_active));
          check("frame_done", RL, int'(bus.frame_done), int'(m_active && m_k == N + RL + 1));
          check("bram_rdaddress", RL, int'(bus.bram_rdaddress), (m_active && m_k < N) ? m_k : 0);
          check("rdaddress", RL, int'(bus.rdaddress), ea);
          check("col", RL, int'(bus.col), ea % W);
          check("row", RL, int'(bus.row), ea / W);
          if (ev) check("rddata", RL, int'(bus.rddata), ea & 12'hFFF);

          // literal pins on the frame geometry
          if (bus.pixel_valid && bus.rdaddress == AB'(19)) begin
            check("col@19", RL, int'(bus.col), 19);
            check("row@19", RL, int'(bus.row), 0);
          end
          if (bus.pixel_valid && bus.rdaddress == AB'(20)) begin
            check("col@20", RL, int'(bus.col), 0);
            check("row@20", RL, int'(bus.row), 1);
          end
          if (bus.pixel_valid && bus.rdaddress == AB'(239)) begin
            check("col@239", RL, int'(bus.col), 19);
            check("row@239", RL, int'(bus.row), 11);
          end
          if (lat_req && bus.pixel_valid && lat_for != t0) begin
            check("first_valid_latency", RL, cyc - t0, RL + 2);
            lat_for = t0;
          end

          if (bus.pixel_valid) valid_cnt++;
          if (bus.frame_done) begin
            check("valid_cycles_per_scan", RL, valid_cnt, 240);
            $display("[RL=%0d] cycle %0d: scan done, %0d pixels", RL, cyc, valid_cnt);
            valid_cnt = 0;
          end
        end
      end
    end
  end

  task automatic tick(int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse();
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    frame_ready = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(5);

    // single scan with first-valid latency measurement
    t0 = cyc;
    lat_req = 1'b1;
    pulse();
    tick(N + 20);
    lat_req = 1'b0;

    // three requests mid-scan collapse into one back-to-back scan
    pulse();
    tick(50);
    pulse();
    tick(7);
    pulse();
    tick(30);
    pulse();
    tick(2 * N + 40);

    // reset in the middle of a scan, then a clean restart
    pulse();
    tick(100);
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    tick(20);
    pulse();
    tick(N + 20);

    // long idle stretch
    tick(1000);

    // random requests and occasional resets
    for (int i = 0; i < 4000; i++) begin
      frame_ready = ($urandom_range(0, 149) == 0);
      reset       = ($urandom_range(0, 2999) == 0);
      @(negedge clk);
    end
    frame_ready = 1'b0;
    reset = 1'b0;
    tick(2 * N + 40);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
